// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state type and default geometry/timing constants
// for the asynchronous SRAM controller.
package sram_pkg;

    // Default SRAM geometry and strobe length
    localparam int ADDR_W      = 18;
    localparam int DATA_W      = 16;
    localparam int WAIT_CYCLES = 2;

    // Controller states; TURN is only entered when read turnaround is enabled
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        TURN
    } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller.
// One access at a time. A read holds oe_n low for WAIT_CYCLES cycles. A write
// takes one setup cycle, then WAIT_CYCLES cycles with we_n low, then one hold cycle.
// All SRAM strobes, the address and the read data are registered.
// Optional build macro SRAM_CTRL_TURNAROUND_EN: after every read, the controller
// spends one extra idle-bus cycle (TURN) before it accepts the next request.
module sram_ctrl #(
    parameter int ADDR_W      = sram_pkg::ADDR_W,
    parameter int DATA_W      = sram_pkg::DATA_W,
    parameter int WAIT_CYCLES = sram_pkg::WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    import sram_pkg::*;

    localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] wdata_q;
    logic              bus_drive;

    // The bus is driven only while a write is in progress, so a reset drops it at once
    assign bus_drive = (state == WR_SETUP) || (state == WR_STROBE) || (state == WR_HOLD);
    assign sram_data = bus_drive ? wdata_q : {DATA_W{1'bz}};

    // Access sequencer: accepts requests, times the strobes, and produces the completion pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            wdata_q     <= '0;
            sram_addr   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            ready       <= 1'b1;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        sram_addr <= addr;
                        wdata_q   <= wdata;
                        sram_ce_n <= 1'b0;
                        ready     <= 1'b0;
                        if (we) begin
                            state <= WR_SETUP;
                        end else begin
                            state     <= RD;
                            sram_oe_n <= 1'b0;
                            wait_cnt  <= CNT_LOAD;
                        end
                    end
                end
                RD: begin
                    if (wait_cnt == CNT_LAST) begin
                        rdata       <= sram_data;
                        rdata_valid <= 1'b1;
                        sram_oe_n   <= 1'b1;
                        sram_ce_n   <= 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
                        state       <= TURN;
`else
                        state       <= IDLE;
                        ready       <= 1'b1;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - CNT_LAST;
                    end
                end
                WR_SETUP: begin
                    state     <= WR_STROBE;
                    sram_we_n <= 1'b0;
                    wait_cnt  <= CNT_LOAD;
                end
                WR_STROBE: begin
                    if (wait_cnt == CNT_LAST) begin
                        state     <= WR_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_LAST;
                    end
                end
                WR_HOLD: begin
                    state     <= IDLE;
                    sram_ce_n <= 1'b1;
                    done      <= 1'b1;
                    ready     <= 1'b1;
                end
                TURN: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    ready     <= 1'b1;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, strobe length in clk cycles; legal range 1..15.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  1  access request; transfers at a rising edge where req=1 and ready=1.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  ADDR_W  access address; sampled with req.
REQ-009 wdata  input  DATA_W  write data; sampled with req.
REQ-010 ready  output  1  controller idle, request accepted this cycle.
REQ-011 rdata  output  DATA_W  last read data, registered, held until next read.
REQ-012 rdata_valid  output  1  one-cycle pulse when rdata updates.
REQ-013 done  output  1  one-cycle pulse when a write completes.
REQ-014 sram_addr  output  ADDR_W  registered SRAM address.
REQ-015 sram_data  inout  DATA_W  SRAM data bus, tristated when not writing.
REQ-016 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  registered active-low SRAM strobes.

Function
REQ-017 FSM states SHALL be IDLE, RD, WR_SETUP, WR_STROBE, WR_HOLD, TURN.
REQ-018 IDLE: ready=1, all strobes high, bus Z; on req accepted, latch addr into sram_addr and wdata, drive sram_ce_n=0, go to RD (we=0) or WR_SETUP (we=1).
REQ-019 RD: sram_oe_n=0 for exactly WAIT_CYCLES cycles; at the last edge, capture sram_data into rdata, pulse rdata_valid the next cycle, release oe_n/ce_n, go to IDLE (or TURN per REQ-029).
REQ-020 WR_SETUP: 1 cycle, bus driven with wdata, sram_we_n=1 (address/data setup).
REQ-021 WR_STROBE: sram_we_n=0 for exactly WAIT_CYCLES cycles, bus driven.
REQ-022 WR_HOLD: 1 cycle, sram_we_n=1, bus still driven; then go to IDLE, release ce_n, tristate bus, pulse done.
REQ-023 Read occupancy SHALL be WAIT_CYCLES cycles; write occupancy WAIT_CYCLES+2 cycles; ready=0 throughout.
REQ-024 Back-to-back requests: with req held high, the next access SHALL be accepted in the first cycle ready returns to 1; no cycle lost beyond REQ-029.
REQ-025 req/we/addr/wdata changes while ready=0 SHALL be ignored; latched values SHALL be stable for the whole access.
REQ-026 sram_oe_n and sram_we_n SHALL never be low in the same cycle; bus SHALL be driven only in WR_SETUP/WR_STROBE/WR_HOLD.
REQ-027 Wait counter SHALL be sized ceil(log2(WAIT_CYCLES+1)) bits, loaded at state entry, no wrap.

Reset
REQ-028 rst low SHALL immediately force IDLE, ce_n/oe_n/we_n=1, bus Z, sram_addr=0, rdata=0, rdata_valid=0, done=0, ready=1 after release; an aborted access SHALL produce no rdata_valid or done.

Configuration
REQ-029 Macro SRAM_CTRL_TURNAROUND_EN: when defined, every read completion SHALL pass through TURN (1 cycle, ready=0, all strobes high, bus Z) before IDLE; when undefined, TURN is unreachable and reads return directly to IDLE.

Structure
REQ-030 Package sram_pkg SHALL hold the FSM state typedef and default parameter constants (ADDR_W, DATA_W, WAIT_CYCLES).
REQ-031 No sub-module; counter, FSM and tristate driver SHALL be inline in sram_ctrl.

Verification (WAIT_CYCLES=2)
REQ-032 Write addr=0x00123, wdata=0xBEEF -> we_n low exactly 2 cycles, data driven 4 cycles, done pulse 4 cycles after acceptance.
REQ-033 Read addr=0x00123 with model returning 0xBEEF -> oe_n low 2 cycles, rdata=0xBEEF with rdata_valid pulse; rdata holds afterwards.
REQ-034 req held high, read then write back-to-back -> write accepted first ready cycle; with SRAM_CTRL_TURNAROUND_EN exactly one extra ready=0 cycle, bus Z in it.
REQ-035 rst asserted during WR_STROBE -> we_n=1 and bus Z asynchronously; no done pulse; next read works.
REQ-036 addr/wdata toggled while ready=0 -> sram_addr and driven data unchanged; oe_n and we_n never both low (assertion).
